usb_out_pio: RTL and testbench

USB_OUT_PIO -- requirements
Module: usb_out_pio

---
 rtl/usb_out_pio_pkg.sv | 15 +
 rtl/usb_out_pio_pulse_timer.sv | 59 +++++
 rtl/usb_out_pio.sv | 116 +++++++++++
 tb/tb_usb_out_pio.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/usb_out_pio_pkg.sv
// Shared register map and pulse-timer state encoding for usb_out_pio.
package usb_out_pio_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_PLEN   = 3'd1;
   localparam logic [2:0] ADDR_PULSE  = 3'd2;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } pulse_state_e;

endpackage

// File: rtl/usb_out_pio_pulse_timer.sv
// Pulse-length timer: counts a loaded length down, busy while running,
// single-cycle done on the final cycle of the pulse.
module usb_out_pio_pulse_timer
   import usb_out_pio_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done
);

   pulse_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACTIVE;
               cnt_d   = len;
            end
         end
         ST_ACTIVE: begin
            // The count of 1 marks the last forced cycle of the pulse.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done    = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == ST_ACTIVE);

endmodule

// File: rtl/usb_out_pio.sv
// Avalon-MM output PIO with DATA/OUTSET/OUTCLR registers; the timed pulse
// generator (PLEN/PULSE registers) exists only when USB_OUT_PIO_PULSE_EN is defined.
module usb_out_pio
   import usb_out_pio_pkg::*;
#(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] data_q, data_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             busy;
   logic [WIDTH-1:0] pulse_bits;
   logic [WIDTH-1:0] pulse_clr;
   logic [31:0]      plen_rd;
   logic             unused_ok;

   assign wr = chipselect && !write_n;
   assign wd = writedata[WIDTH-1:0];

`ifdef USB_OUT_PIO_PULSE_EN
   logic [CNT_W-1:0] plen_q, plen_d;
   logic [WIDTH-1:0] pmask_q, pmask_d;
   logic             pulse_go;
   logic             pulse_done;

   // Zero length, zero mask or a pulse already running all drop the request.
   assign pulse_go = wr && (address == ADDR_PULSE) && !busy
                     && (plen_q != '0) && (wd != '0);

   always_comb begin
      plen_d  = plen_q;
      pmask_d = pmask_q;
      if (wr && (address == ADDR_PLEN)) plen_d = writedata[CNT_W-1:0];
      if (pulse_go) pmask_d = wd;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         plen_q  <= '0;
         pmask_q <= '0;
      end else begin
         plen_q  <= plen_d;
         pmask_q <= pmask_d;
      end
   end

   usb_out_pio_pulse_timer #(.CNT_W(CNT_W)) u_pulse_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (pulse_go),
      .len     (plen_q),
      .busy    (busy),
      .done    (pulse_done)
   );

   assign pulse_bits = busy ? pmask_q : '0;
   assign pulse_clr  = pulse_done ? pmask_q : '0;
   assign plen_rd    = 32'(plen_q);
   assign unused_ok  = ^writedata;
`else
   assign busy       = 1'b0;
   assign pulse_bits = '0;
   assign pulse_clr  = '0;
   assign plen_rd    = '0;
   assign unused_ok  = ^{writedata, {CNT_W{1'b0}}};
`endif

   // Pulse-end clear first, so a same-cycle bus write takes precedence.
   always_comb begin
      data_d = data_q & ~pulse_clr;
      if (wr) begin
         case (address)
            ADDR_DATA:   data_d = wd;
            ADDR_OUTSET: data_d = data_d | wd;
            ADDR_OUTCLR: data_d = data_d & ~wd;
            default:     ;
         endcase
      end
   end

   always_comb begin
      case (address)
         ADDR_DATA:  readdata_d = 32'(data_q);
         ADDR_PLEN:  readdata_d = plen_rd;
         ADDR_PULSE: readdata_d = {31'd0, busy};
         default:    readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         readdata_q <= '0;
      end else begin
         data_q     <= data_d;
         readdata_q <= readdata_d;
      end
   end

   assign out_port = data_q | pulse_bits;
   assign readdata = readdata_q;

endmodule

// File: tb/tb_usb_out_pio.sv
// Directed and randomized bench for usb_out_pio (WIDTH=4, RESET_VALUE=1),
// checked against a cycle-level model of remaining pulse cycles.
module tb_usb_out_pio;

`ifdef USB_OUT_PIO_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif
   localparam logic [3:0] RV    = 4'h1;
   localparam int         EXP3  = PULSE_EN ? 3 : 0;
   localparam int         EXP10 = PULSE_EN ? 10 : 0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [3:0]  out_port;

   int n_assert = 0;
   int n_fail   = 0;
   int n_high;

   logic [3:0]  m_data, m_mask;
   int unsigned m_plen, m_remain;
   logic [31:0] m_rd;

   usb_out_pio #(.WIDTH(4), .RESET_VALUE(RV), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_data = RV; m_mask = 4'h0; m_plen = 0; m_remain = 0; m_rd = 32'd0;
   endtask

   function automatic logic [3:0] m_out();
      return m_data | ((m_remain != 0) ? m_mask : 4'h0);
   endfunction

   // One rising edge of the spec's behaviour, using the bus inputs present at that edge.
   task automatic model_edge();
      logic       wr;
      logic [3:0] wd4;
      logic       was_busy;
      logic       ending;
      wr       = chipselect && !write_n;
      wd4      = writedata[3:0];
      was_busy = (m_remain != 0);
      case (address)
         3'd0:    m_rd = {28'd0, m_data};
         3'd1:    m_rd = m_plen;
         3'd2:    m_rd = {31'd0, was_busy};
         default: m_rd = 32'd0;
      endcase
      ending = (m_remain == 1);
      if (was_busy) m_remain = m_remain - 1;
      if (ending) m_data = m_data & ~m_mask;
      if (wr) begin
         case (address)
            3'd0: m_data = wd4;
            3'd4: m_data = m_data | wd4;
            3'd5: m_data = m_data & ~wd4;
            3'd1: if (PULSE_EN) m_plen = writedata & 32'hFFFF;
            3'd2: if (PULSE_EN && !was_busy && m_plen != 0 && wd4 != 4'h0) begin
                     m_mask   = wd4;
                     m_remain = m_plen;
                  end
            default: ;
         endcase
      end
   endtask

   task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
      @(negedge clk);
      address = a; chipselect = cs; write_n = wn; writedata = wd;
      @(posedge clk);
      model_edge();
      #1;
      check("out_port", {28'd0, out_port}, {28'd0, m_out()});
      check("readdata", readdata, m_rd);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
      cycle(a, 1'b1, 1'b0, wd);
   endtask

   task automatic count_high(input int cycles, inout int n);
      for (int i = 0; i < cycles; i++) begin
         cycle(3'd2, 1'b1, 1'b1, 32'd0);
         if (out_port[0]) n++;
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_port", {28'd0, out_port}, 32'h1);
      check("reset_readdata", readdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      cycle(3'd0, 1'b0, 1'b1, 32'd0);
      check("read_data_after_reset", readdata, 32'h1);

      wr_reg(3'd0, 32'h5);
      check("data_write", {28'd0, out_port}, 32'h5);
      wr_reg(3'd4, 32'h2);
      check("outset_write", {28'd0, out_port}, 32'h7);
      wr_reg(3'd5, 32'h4);
      check("outclr_write", {28'd0, out_port}, 32'h3);

      wr_reg(3'd1, 32'd3);
      wr_reg(3'd0, 32'd0);
      n_high = 0;
      wr_reg(3'd2, 32'h1);
      if (out_port[0]) n_high++;
      count_high(8, n_high);
      check("pulse_len_3", n_high, EXP3);

      n_high = 0;
      wr_reg(3'd2, 32'h1);
      if (out_port[0]) n_high++;
      wr_reg(3'd2, 32'h1);
      if (out_port[0]) n_high++;
      wr_reg(3'd1, 32'd10);
      if (out_port[0]) n_high++;
      count_high(8, n_high);
      check("pulse_len_unchanged", n_high, EXP3);
      n_high = 0;
      wr_reg(3'd2, 32'h1);
      if (out_port[0]) n_high++;
      count_high(14, n_high);
      check("pulse_len_10", n_high, EXP10);

      wr_reg(3'd1, 32'd0);
      n_high = 0;
      wr_reg(3'd2, 32'h1);
      if (out_port[0]) n_high++;
      count_high(3, n_high);
      check("pulse_plen0_ignored", n_high, 0);

      wr_reg(3'd1, 32'd5);
      wr_reg(3'd2, 32'hF);
      cycle(3'd2, 1'b0, 1'b1, 32'd0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_reset_out_port", {28'd0, out_port}, 32'h1);
      check("async_reset_readdata", readdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      cycle(3'd2, 1'b1, 1'b1, 32'd0);
      check("busy_after_reset", readdata, 32'h0);

      for (int i = 0; i < 400; i++) begin
         logic [2:0] a;
         a = 3'($urandom_range(0, 7));
         cycle(a, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               (a == 3'd1) ? 32'($urandom_range(0, 6)) : $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
